conv_window_sequencer: RTL
==========================

Name: conv_window_sequencer

Overview:
Controller that sequences the serial convolution MAC over a full feature map. For each output pixel it scans the K_H×K_W window and issues image and weight read addresses, one tap per cycle. It drives the MAC clear, enable, pad and last strobes, waits for the MAC result, then hands the result address downstream with a ready/valid handshake. It sits between the image/weight buffers and the conv MAC, and is started by the layer control.

Parameters:
IMG_W, 4, input feature-map width in pixels
IMG_H, 4, input feature-map height in pixels
K_W, 2, kernel width
K_H, 2, kernel height
STRIDE, 1, window step in x and y (≥1)
PAD, 0, zero-padding border width in pixels (0..K_W-1)
ADDR_W, 8, width of img_addr/weight_addr/out_addr
RES_W, (IMG_W-K_W+2*PAD)/STRIDE+1, output width (derived)
RES_H, (IMG_H-K_H+2*PAD)/STRIDE+1, output height (derived)

Ports:
clk_en  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a layer when IDLE
abort  in  1  synchronous abort; returns to IDLE next edge
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse after the final output write is accepted
img_addr  out  ADDR_W  image read address; iy*IMG_W+ix, or 0 when padded
weight_addr  out  ADDR_W  weight read address; ky*K_W+kx
mac_clr  out  1  clears the MAC accumulator (1 cycle)
mac_en  out  1  tap valid to the MAC; lags its address by 1 cycle (buffer read latency)
mac_pad  out  1  tap is padding; MAC must use 0 for the pixel; aligned with mac_en
mac_last  out  1  final tap of the window; aligned with mac_en
res_valid  in  1  MAC result ready (pulse or level)
out_addr  out  ADDR_W  result address; oy*RES_W+ox
out_wr  out  1  write request for the result; valid in WRITE state
out_ready  in  1  downstream accepts when out_wr & out_ready
err  out  1  timeout flag (see Optional Feature); else tied 0

Behaviour:
- Reset: state=IDLE; all outputs, counters (ox, oy, kx, ky) and the address outputs are 0.
- States are IDLE, CLR, TAP, WAIT, WRITE, DONE.
- IDLE: start=1 → CLR; ox=oy=0. A start pulse in any other state is ignored.
- CLR: mac_clr=1 for one cycle; kx=ky=0 → TAP.
- TAP: one tap per cycle with kx fastest, then ky. Addresses are registered outputs.
  - ix=ox*STRIDE+kx-PAD and iy=oy*STRIDE+ky-PAD, as signed arithmetic at ADDR_W+2 bits.
  - If ix<0, ix≥IMG_W, iy<0 or iy≥IMG_H: the tap is padded, img_addr=0 and the delayed mac_pad=1.
  - mac_en, mac_pad and mac_last are the tap strobes delayed by one register stage.
  - After the K_W*K_H-th tap → WAIT.
- WAIT: stay until res_valid=1, then → WRITE. res_valid outside WAIT is ignored.
- WRITE: out_wr=1 and out_addr stable until out_ready=1. On accept, advance ox; wrap to 0 at RES_W with oy+1.
  - If (ox,oy) was (RES_W-1,RES_H-1) → DONE; else → CLR.
- DONE: done=1 for one cycle → IDLE; busy falls the same edge.
- abort=1 in any state → IDLE on the next edge. All outputs clear and done is not pulsed. abort has priority over start.
- Async reset mid-operation: immediate return to reset values; no partial done.
- Minimum cycles per output = 1 (CLR) + K_W*K_H (TAP) + 1 (WAIT, if res_valid is immediate) + 1 (WRITE, if out_ready is high).

Optional Feature:
- Macro CONV_SEQ_TIMEOUT_EN.
- Defined: a 16-bit counter runs in WAIT.
  - If 1024 cycles pass without res_valid: err is set (sticky until next start or reset) and the state goes → IDLE without done.
- Undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
- Defaults (4×4 image, 2×2 kernel, stride 1, pad 0), start, res_valid one cycle after mac_last, out_ready=1 → 9 writes to out_addr 0..8.
  - Window 0 img_addr 0,1,4,5; window 8 img_addr 10,11,14,15; weight_addr 0,1,2,3 per window; done one cycle after the 9th accept.
- STRIDE=2 → 4 outputs; first tap per window at img_addr 0,2,8,10; out_addr 0..3; done pulses once.
- PAD=1 → RES_W=RES_H=5.
  - Window 0: mac_pad pattern 1,1,1,0 with the last img_addr=0.
  - Window 24: mac_pad 0,1,1,1 with the first img_addr=15.
- Backpressure: out_ready low for 3 cycles on output 4 → out_wr held 4 cycles, out_addr=4 stable, no next mac_clr until accept.
- abort asserted during the 3rd tap of output 2 → IDLE next cycle, busy=0, no done. A following start restarts at out_addr 0.
- With CONV_SEQ_TIMEOUT_EN, res_valid never asserted → err=1 after 1024 WAIT cycles, IDLE, done stays 0. Next start clears err.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// Sequences the serial convolution MAC across a feature map: window scan, MAC strobes, result handoff.
// Optional WAIT-state timeout with sticky err is enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv_window_sequencer #(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K_W    = 2,
    parameter int K_H    = 2,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    parameter int ADDR_W = 8
) (
    input  logic              clk_en,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_pad,
    output logic              mac_last,
    input  logic              res_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_wr,
    input  logic              out_ready,
    output logic              err
);
    localparam int RES_W = (IMG_W - K_W + 2 * PAD) / STRIDE + 1;
    localparam int RES_H = (IMG_H - K_H + 2 * PAD) / STRIDE + 1;
    localparam int SW    = ADDR_W + 2;

    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] KX_LAST = ADDR_W'(K_W - 1);
    localparam logic [ADDR_W-1:0] KY_LAST = ADDR_W'(K_H - 1);
    localparam logic [ADDR_W-1:0] OX_LAST = ADDR_W'(RES_W - 1);
    localparam logic [ADDR_W-1:0] OY_LAST = ADDR_W'(RES_H - 1);

    localparam logic signed [SW-1:0] STRIDE_S = SW'(STRIDE);
    localparam logic signed [SW-1:0] PAD_S    = SW'(PAD);
    localparam logic signed [SW-1:0] IMG_W_S  = SW'(IMG_W);
    localparam logic signed [SW-1:0] IMG_H_S  = SW'(IMG_H);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_TAP, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ox_q, ox_d, oy_q, oy_d, kx_q, kx_d, ky_q, ky_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d, weight_addr_q, weight_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              mac_clr_q, mac_clr_d, out_wr_q, out_wr_d, done_q, done_d, busy_q, busy_d;
    logic              tap_q, tap_d, tap_pad_q, tap_pad_d, tap_last_q, tap_last_d;
    logic              mac_en_q, mac_en_d, mac_pad_q, mac_pad_d, mac_last_q, mac_last_d;

    logic              issue, go_idle, tap_is_pad;
    logic [ADDR_W-1:0] nkx, nky;
    logic signed [SW-1:0] ix_s, iy_s;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'd1023;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d       = state_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        kx_d          = kx_q;
        ky_d          = ky_q;
        img_addr_d    = img_addr_q;
        weight_addr_d = weight_addr_q;
        out_addr_d    = out_addr_q;
        mac_clr_d     = 1'b0;
        tap_d         = 1'b0;
        tap_pad_d     = 1'b0;
        tap_last_d    = 1'b0;
        mac_en_d      = tap_q;
        mac_pad_d     = tap_pad_q;
        mac_last_d    = tap_last_q;
        out_wr_d      = 1'b0;
        done_d        = 1'b0;
        issue         = 1'b0;
        go_idle       = abort;
        nkx           = '0;
        nky           = '0;
`ifdef CONV_SEQ_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_CLR;
                    ox_d      = '0;
                    oy_d      = '0;
                    mac_clr_d = 1'b1;
`ifdef CONV_SEQ_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            S_CLR: begin
                state_d = S_TAP;
                issue   = 1'b1;
            end
            S_TAP: begin
                if (kx_q == KX_LAST && ky_q == KY_LAST) begin
                    state_d    = S_WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    issue = 1'b1;
                    if (kx_q == KX_LAST) begin
                        nky = ky_q + ONE;
                    end else begin
                        nkx = kx_q + ONE;
                        nky = ky_q;
                    end
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    state_d    = S_WRITE;
                    out_wr_d   = 1'b1;
                    out_addr_d = ADDR_W'(oy_q * RES_W + ox_q);
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    go_idle = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            S_WRITE: begin
                out_wr_d = 1'b1;
                if (out_ready) begin
                    out_wr_d = 1'b0;
                    if (ox_q == OX_LAST) begin
                        ox_d = '0;
                        oy_d = oy_q + ONE;
                    end else begin
                        ox_d = ox_q + ONE;
                    end
                    if (ox_q == OX_LAST && oy_q == OY_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_CLR;
                        mac_clr_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Window origin is shifted by PAD, so taps can land outside the image on any side.
        ix_s       = $signed(SW'(ox_q)) * STRIDE_S + $signed(SW'(nkx)) - PAD_S;
        iy_s       = $signed(SW'(oy_q)) * STRIDE_S + $signed(SW'(nky)) - PAD_S;
        tap_is_pad = ix_s[SW-1] || iy_s[SW-1] || (ix_s >= IMG_W_S) || (iy_s >= IMG_H_S);

        if (issue) begin
            kx_d          = nkx;
            ky_d          = nky;
            img_addr_d    = tap_is_pad ? '0 : ADDR_W'(iy_s * IMG_W_S + ix_s);
            weight_addr_d = ADDR_W'(nky * K_W + nkx);
            tap_d         = 1'b1;
            tap_pad_d     = tap_is_pad;
            tap_last_d    = (nkx == KX_LAST) && (nky == KY_LAST);
        end

        if (go_idle) begin
            state_d       = S_IDLE;
            ox_d          = '0;
            oy_d          = '0;
            kx_d          = '0;
            ky_d          = '0;
            img_addr_d    = '0;
            weight_addr_d = '0;
            out_addr_d    = '0;
            mac_clr_d     = 1'b0;
            tap_d         = 1'b0;
            tap_pad_d     = 1'b0;
            tap_last_d    = 1'b0;
            mac_en_d      = 1'b0;
            mac_pad_d     = 1'b0;
            mac_last_d    = 1'b0;
            out_wr_d      = 1'b0;
            done_d        = 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            wait_cnt_d    = '0;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ox_q          <= '0;
            oy_q          <= '0;
            kx_q          <= '0;
            ky_q          <= '0;
            img_addr_q    <= '0;
            weight_addr_q <= '0;
            out_addr_q    <= '0;
            mac_clr_q     <= 1'b0;
            tap_q         <= 1'b0;
            tap_pad_q     <= 1'b0;
            tap_last_q    <= 1'b0;
            mac_en_q      <= 1'b0;
            mac_pad_q     <= 1'b0;
            mac_last_q    <= 1'b0;
            out_wr_q      <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            kx_q          <= kx_d;
            ky_q          <= ky_d;
            img_addr_q    <= img_addr_d;
            weight_addr_q <= weight_addr_d;
            out_addr_q    <= out_addr_d;
            mac_clr_q     <= mac_clr_d;
            tap_q         <= tap_d;
            tap_pad_q     <= tap_pad_d;
            tap_last_q    <= tap_last_d;
            mac_en_q      <= mac_en_d;
            mac_pad_q     <= mac_pad_d;
            mac_last_q    <= mac_last_d;
            out_wr_q      <= out_wr_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
`ifdef CONV_SEQ_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign img_addr    = img_addr_q;
    assign weight_addr = weight_addr_q;
    assign out_addr    = out_addr_q;
    assign mac_clr     = mac_clr_q;
    assign mac_en      = mac_en_q;
    assign mac_pad     = mac_pad_q;
    assign mac_last    = mac_last_q;
    assign out_wr      = out_wr_q;
`ifdef CONV_SEQ_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule
